share_decoder: RTL

Sequential unmasking endpoint for the masked-multiplier datapath. It accepts one SHARES-way Boolean-masked value per valid/ready handshake, such as the z output of a first-order gadget. It recombines the shares one per cycle so that no single combinational cone ever sees all shares at once, then presents the unmasked result on a valid/ready output. Share storage is zeroized after every transaction.

---
 rtl/share_pkg.sv | 29 ++
 rtl/share_xor_acc.sv | 41 ++++
 rtl/share_decoder.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/share_pkg.sv
// Shared types, defaults and helpers for the share decoder.
// Consumed by share_decoder and share_xor_acc via import share_pkg::*.
package share_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REFRESH = 2'd1,
      ST_FOLD    = 2'd2,
      ST_DONE    = 2'd3
   } dec_state_e;

   localparam int unsigned SHARES_DEF  = 2;
   localparam int unsigned SLICE_MAX_W = 64;
   localparam int unsigned VEC_MAX_W   = 1024;

   // Extract share i of width w from a zero-extended packed share vector.
   function automatic logic [SLICE_MAX_W-1:0] share_slice(
      input logic [VEC_MAX_W-1:0] vec,
      input int unsigned          i,
      input int unsigned          w
   );
      logic [VEC_MAX_W-1:0]   shifted;
      logic [SLICE_MAX_W-1:0] mask;
      shifted = vec >> (i * w);
      mask    = (w >= SLICE_MAX_W) ? '1 : ~({SLICE_MAX_W{1'b1}} << w);
      return shifted[SLICE_MAX_W-1:0] & mask;
   endfunction

endpackage

// File: rtl/share_xor_acc.sv
// Registered XOR accumulator used to fold shares one at a time.
// Clear wins over load, load wins over xor.
module share_xor_acc
   import share_pkg::*;
#(
   parameter int unsigned WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             xor_en_i,
   input  logic [WIDTH-1:0] xor_val_i,
   output logic [WIDTH-1:0] acc_o
);

   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] acc_d;

   always_comb begin
      acc_d = acc_q;
      unique case (1'b1)
         clr_i:    acc_d = '0;
         load_i:   acc_d = load_val_i;
         xor_en_i: acc_d = acc_q ^ xor_val_i;
         default:  acc_d = acc_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/share_decoder.sv
// Sequential unmasking endpoint: folds Boolean shares one per cycle.
// Optional share re-randomization before folding under DEC_REFRESH_EN.
module share_decoder
   import share_pkg::*;
#(
   parameter int unsigned WIDTH  = 2,
   parameter int unsigned SHARES = SHARES_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [SHARES*WIDTH-1:0] in_shares,
`ifdef DEC_REFRESH_EN
   input  logic [WIDTH-1:0]        rnd,
`endif
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_data
);

   localparam int unsigned IDX_W = (SHARES > 1) ? $clog2(SHARES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SHARES - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   dec_state_e state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [WIDTH-1:0] sh_q [SHARES];
   logic [WIDTH-1:0] sh_d [SHARES];

   logic             acc_clr;
   logic             acc_ld;
   logic [WIDTH-1:0] acc_ld_val;
   logic             acc_xe;
   logic [WIDTH-1:0] acc_xv;
   logic [WIDTH-1:0] acc_q;

   logic [VEC_MAX_W-1:0]   in_vec;
   logic [SLICE_MAX_W-1:0] slice_tmp;

   logic st_idle, st_fold, st_done;
`ifdef DEC_REFRESH_EN
   logic st_refresh;
   assign st_refresh = (state_q == ST_REFRESH);
`endif

   assign st_idle = (state_q == ST_IDLE);
   assign st_fold = (state_q == ST_FOLD);
   assign st_done = (state_q == ST_DONE);

   assign in_vec    = VEC_MAX_W'(in_shares);
   assign in_ready  = st_idle;
   assign out_valid = st_done;
   // Partial folds never leave the block: data is gated by valid.
   assign out_data  = st_done ? acc_q : '0;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      acc_clr    = 1'b0;
      acc_ld     = 1'b0;
      acc_ld_val = '0;
      acc_xe     = 1'b0;
      acc_xv     = '0;
      slice_tmp  = '0;
      for (int unsigned i = 0; i < SHARES; i++) begin
         sh_d[i] = sh_q[i];
      end
      unique case (1'b1)
         st_idle: begin
            if (in_valid) begin
               for (int unsigned i = 0; i < SHARES; i++) begin
                  slice_tmp = share_slice(in_vec, i, WIDTH);
                  sh_d[i]   = slice_tmp[WIDTH-1:0];
               end
`ifdef DEC_REFRESH_EN
               state_d = ST_REFRESH;
`else
               acc_ld     = 1'b1;
               acc_ld_val = sh_d[0];
               idx_d      = IDX_ONE;
               state_d    = ST_FOLD;
`endif
            end
         end
`ifdef DEC_REFRESH_EN
         st_refresh: begin
            sh_d[0]    = sh_q[0] ^ rnd;
            sh_d[1]    = sh_q[1] ^ rnd;
            acc_ld     = 1'b1;
            acc_ld_val = sh_q[0] ^ rnd;
            idx_d      = IDX_ONE;
            state_d    = ST_FOLD;
         end
`endif
         st_fold: begin
            acc_xe = 1'b1;
            acc_xv = sh_q[idx_q];
            if (idx_q == IDX_LAST) begin
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + IDX_ONE;
            end
         end
         st_done: begin
            if (out_ready) begin
               for (int unsigned i = 0; i < SHARES; i++) begin
                  sh_d[i] = '0;
               end
               acc_clr = 1'b1;
               idx_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         for (int unsigned i = 0; i < SHARES; i++) begin
            sh_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         for (int unsigned i = 0; i < SHARES; i++) begin
            sh_q[i] <= sh_d[i];
         end
      end
   end

   share_xor_acc #(
      .WIDTH(WIDTH)
   ) u_acc (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (acc_clr),
      .load_i     (acc_ld),
      .load_val_i (acc_ld_val),
      .xor_en_i   (acc_xe),
      .xor_val_i  (acc_xv),
      .acc_o      (acc_q)
   );

endmodule
